instruction_queue: RTL and testbench

//  FIFO between instruction fetch and issue. Buffers fetched {instruction, pc} pairs and issues
//  at most one per cycle to decoder/ROB/RS/LSB via get_instruction while no downstream is full.

---
 rtl/instruction_queue_pkg.sv | 20 ++
 rtl/instruction_queue_ring_buffer.sv | 81 ++++++++
 rtl/instruction_queue.sv | 133 +++++++++++++
 tb/tb_instruction_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// -----------------------------------------------------------------------------
// instruction_queue_pkg
//   Shared definitions for the instruction queue: boolean constants, default
//   geometry and the packed {instruction, pc} entry carried through the queue.
//   No ports (package).
// -----------------------------------------------------------------------------
package instruction_queue_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ISQ_SIZE_DEF   = 16;
    localparam int ISQ_ADDR_W_DEF = 4;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } isq_entry_t;

endpackage : instruction_queue_pkg

// File: rtl/instruction_queue_ring_buffer.sv
// -----------------------------------------------------------------------------
// instruction_queue_ring_buffer
//   Circular storage for {instruction, pc} entries with head/rear pointers and
//   an occupancy count. The count is the only full/empty discriminator; the
//   pointers simply wrap at the buffer size.
// Ports
//   clk_in    : clock
//   rst_n_in  : asynchronous active-low reset (clears pointers and count)
//   srst      : synchronous clear (flush), takes priority over push/pop
//   push      : write wr_entry at rear (caller guarantees not full)
//   pop       : retire entry at head (caller guarantees not empty)
//   wr_entry  : entry to write
//   rd_entry  : entry currently at head (combinational read)
//   count     : current occupancy, ADDR_W+1 bits
// -----------------------------------------------------------------------------
module instruction_queue_ring_buffer
    import instruction_queue_pkg::*;
#(
    parameter int ADDR_W = ISQ_ADDR_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              srst,
    input  logic              push,
    input  logic              pop,
    input  isq_entry_t        wr_entry,
    output isq_entry_t        rd_entry,
    output logic [ADDR_W:0]   count
);

    localparam int SIZE = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

    isq_entry_t        mem_r [SIZE];
    logic [ADDR_W-1:0] head_r;
    logic [ADDR_W-1:0] rear_r;
    logic [ADDR_W:0]   count_r;

    // Pointer and occupancy bookkeeping; flush wins over any push/pop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_r  <= PTR_ZERO;
            rear_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (srst) begin
            head_r  <= PTR_ZERO;
            rear_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push) begin
                rear_r <= rear_r + PTR_ONE;
            end else begin
                rear_r <= rear_r;
            end
            if (pop) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk_in) begin
        if (push && !srst) begin
            mem_r[rear_r] <= wr_entry;
        end
    end

    assign rd_entry = mem_r[head_r];
    assign count    = count_r;

endmodule : instruction_queue_ring_buffer

// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//   FIFO between instruction fetch and issue. Buffers {instruction, pc} pairs
//   and issues at most one per cycle while no downstream unit is stalling.
//   roll_back flushes the queue; rdy_in low freezes everything.
// Build option
//   ISQ_BYPASS_EN : when defined, a push into an empty, unstalled queue goes
//                   straight to the output registers (1-cycle latency) and is
//                   never stored. Undefined: every entry is stored first.
// Ports
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   rdy_in                  : low = pause (state, outputs, roll_back ignored)
//   roll_back               : flush all entries, cancel issue
//   ifetch_valid/ins/pc     : push request from fetch
//   isq_is_full             : back-pressure to fetch (count == ISQ_SIZE)
//   rob/rs/lsb_is_full      : downstream stalls
//   get_instruction         : registered issue valid
//   isq_ins_out, isq_pc_out : registered issued entry (hold when not issuing)
//   isq_count               : current occupancy
// -----------------------------------------------------------------------------
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int ISQ_SIZE   = ISQ_SIZE_DEF,
    parameter int ISQ_ADDR_W = ISQ_ADDR_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic                  ifetch_valid,
    input  logic [31:0]           ifetch_ins,
    input  logic [31:0]           ifetch_pc,
    output logic                  isq_is_full,
    input  logic                  rob_is_full,
    input  logic                  rs_is_full,
    input  logic                  lsb_is_full,
    output logic                  get_instruction,
    output logic [31:0]           isq_ins_out,
    output logic [31:0]           isq_pc_out,
    output logic [ISQ_ADDR_W:0]   isq_count
);

    localparam int CNT_W = ISQ_ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ISQ_SIZE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic       stall_s;
    logic       push_s;
    logic       pop_s;
    logic       bypass_s;
    logic       store_s;
    logic       flush_s;
    isq_entry_t fetch_entry_s;
    isq_entry_t head_entry_s;

    logic        nxt_get_s;
    logic [31:0] nxt_ins_s;
    logic [31:0] nxt_pc_s;

    logic        get_r;
    logic [31:0] ins_r;
    logic [31:0] pc_r;

    assign isq_is_full   = (isq_count == CNT_FULL);
    assign stall_s       = rob_is_full || rs_is_full || lsb_is_full;
    assign flush_s       = rdy_in && roll_back;
    assign push_s        = rdy_in && ifetch_valid && !isq_is_full && !roll_back;
    assign pop_s         = rdy_in && (isq_count != CNT_ZERO) && !stall_s && !roll_back;
    assign fetch_entry_s = '{ins: ifetch_ins, pc: ifetch_pc};

`ifdef ISQ_BYPASS_EN
    assign bypass_s = push_s && (isq_count == CNT_ZERO) && !stall_s;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed word feeds the output registers directly instead of a slot.
    assign store_s = push_s && !bypass_s;

    instruction_queue_ring_buffer #(
        .ADDR_W (ISQ_ADDR_W)
    ) u_ring (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .srst     (flush_s),
        .push     (store_s),
        .pop      (pop_s),
        .wr_entry (fetch_entry_s),
        .rd_entry (head_entry_s),
        .count    (isq_count)
    );

    // Issue selection: stored head has priority; bypass only ever fires when empty.
    always_comb begin
        nxt_get_s = FALSE;
        nxt_ins_s = ins_r;
        nxt_pc_s  = pc_r;
        if (pop_s) begin
            nxt_get_s = TRUE;
            nxt_ins_s = head_entry_s.ins;
            nxt_pc_s  = head_entry_s.pc;
        end else if (bypass_s) begin
            nxt_get_s = TRUE;
            nxt_ins_s = ifetch_ins;
            nxt_pc_s  = ifetch_pc;
        end else begin
            nxt_get_s = FALSE;
        end
    end

    // Output registers; a pause holds valid and data exactly as they are.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            get_r <= FALSE;
            ins_r <= 32'h0000_0000;
            pc_r  <= 32'h0000_0000;
        end else if (rdy_in) begin
            get_r <= nxt_get_s;
            ins_r <= nxt_ins_s;
            pc_r  <= nxt_pc_s;
        end else begin
            get_r <= get_r;
            ins_r <= ins_r;
            pc_r  <= pc_r;
        end
    end

    assign get_instruction = get_r;
    assign isq_ins_out     = ins_r;
    assign isq_pc_out      = pc_r;

endmodule : instruction_queue

// File: tb/tb_instruction_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_queue
//   Directed, self-checking bench for instruction_queue (16 entries).
// -----------------------------------------------------------------------------
module tb_instruction_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        roll_back;
    logic        ifetch_valid;
    logic [31:0] ifetch_ins;
    logic [31:0] ifetch_pc;
    logic        isq_is_full;
    logic        rob_is_full;
    logic        rs_is_full;
    logic        lsb_is_full;
    logic        get_instruction;
    logic [31:0] isq_ins_out;
    logic [31:0] isq_pc_out;
    logic [4:0]  isq_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instruction_queue #(.ISQ_SIZE(16), .ISQ_ADDR_W(4)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rdy_in          (rdy_in),
        .roll_back       (roll_back),
        .ifetch_valid    (ifetch_valid),
        .ifetch_ins      (ifetch_ins),
        .ifetch_pc       (ifetch_pc),
        .isq_is_full     (isq_is_full),
        .rob_is_full     (rob_is_full),
        .rs_is_full      (rs_is_full),
        .lsb_is_full     (lsb_is_full),
        .get_instruction (get_instruction),
        .isq_ins_out     (isq_ins_out),
        .isq_pc_out      (isq_pc_out),
        .isq_count       (isq_count)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b1;
        #1 rst_n_in = 1'b0;
        #1;
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL reset_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", isq_count); else pass_cnt++;
        total_cnt++; if (isq_ins_out !== 32'h0) $display("FAIL reset_ins: got %h want 0", isq_ins_out); else pass_cnt++;
        total_cnt++; if (isq_pc_out !== 32'h0) $display("FAIL reset_pc: got %h want 0", isq_pc_out); else pass_cnt++;
        total_cnt++; if (isq_is_full !== 1'b0) $display("FAIL reset_full: got %b want 0", isq_is_full); else pass_cnt++;
        step();
        rst_n_in = 1'b1;
        step();
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL post_reset_get: got %b want 0", get_instruction); else pass_cnt++;
    endtask

    task automatic test_single_push();
        ifetch_valid = 1'b1; ifetch_ins = 32'h0000_0013; ifetch_pc = 32'h0;
        step();
        ifetch_valid = 1'b0;
`ifdef ISQ_BYPASS_EN
        total_cnt++; if (get_instruction !== 1'b1) $display("FAIL single_get: got %b want 1", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL single_bypass_count: got %0d want 0", isq_count); else pass_cnt++;
`else
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL single_early_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd1) $display("FAIL single_count: got %0d want 1", isq_count); else pass_cnt++;
        step();
        total_cnt++; if (get_instruction !== 1'b1) $display("FAIL single_get: got %b want 1", get_instruction); else pass_cnt++;
`endif
        total_cnt++; if (isq_ins_out !== 32'h0000_0013) $display("FAIL single_ins: got %h want 00000013", isq_ins_out); else pass_cnt++;
        total_cnt++; if (isq_pc_out !== 32'h0) $display("FAIL single_pc: got %h want 0", isq_pc_out); else pass_cnt++;
        step();
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL single_after_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL single_after_count: got %0d want 0", isq_count); else pass_cnt++;
    endtask

    task automatic test_stall_fill();
        rob_is_full  = 1'b1;
        ifetch_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ifetch_ins = 32'h1000 + 32'(i);
            ifetch_pc  = 32'(4 * i);
            step();
        end
        total_cnt++; if (isq_count !== 5'd16) $display("FAIL fill_count: got %0d want 16", isq_count); else pass_cnt++;
        total_cnt++; if (isq_is_full !== 1'b1) $display("FAIL fill_full: got %b want 1", isq_is_full); else pass_cnt++;
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL fill_stall_get: got %b want 0", get_instruction); else pass_cnt++;
        ifetch_ins = 32'h0000_dead; ifetch_pc = 32'h40;
        step();
        total_cnt++; if (isq_count !== 5'd16) $display("FAIL fill_drop_count: got %0d want 16", isq_count); else pass_cnt++;
        ifetch_valid = 1'b0;
        rob_is_full  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            total_cnt++; if (get_instruction !== 1'b1) $display("FAIL drain_get[%0d]: got %b want 1", i, get_instruction); else pass_cnt++;
            total_cnt++; if (isq_pc_out !== 32'(4 * i)) $display("FAIL drain_pc[%0d]: got %h want %h", i, isq_pc_out, 32'(4 * i)); else pass_cnt++;
            total_cnt++; if (isq_ins_out !== 32'h1000 + 32'(i)) $display("FAIL drain_ins[%0d]: got %h want %h", i, isq_ins_out, 32'h1000 + 32'(i)); else pass_cnt++;
            total_cnt++; if (isq_count !== 5'(15 - i)) $display("FAIL drain_count[%0d]: got %0d want %0d", i, isq_count, 15 - i); else pass_cnt++;
        end
        step();
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL drain_end_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL drain_end_count: got %0d want 0", isq_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int  exp_count;
        int  p;
        logic full_pre;
        rob_is_full  = 1'b1;
        ifetch_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ifetch_ins = 32'h2000 + 32'(i);
            ifetch_pc  = 32'h100 + 32'(4 * i);
            step();
        end
        rob_is_full = 1'b0;
        exp_count = 16;
        p = 16;
        ifetch_ins = 32'h2000 + 32'(p);
        ifetch_pc  = 32'h100 + 32'(4 * p);
        for (int k = 0; k < 20; k++) begin
            full_pre = (exp_count == 16);
            step();
            exp_count = exp_count - 1 + (full_pre ? 0 : 1);
            if (!full_pre) begin
                p++;
                ifetch_ins = 32'h2000 + 32'(p);
                ifetch_pc  = 32'h100 + 32'(4 * p);
            end
            total_cnt++; if (get_instruction !== 1'b1) $display("FAIL b2b_get[%0d]: got %b want 1", k, get_instruction); else pass_cnt++;
            total_cnt++; if (isq_pc_out !== 32'h100 + 32'(4 * k)) $display("FAIL b2b_pc[%0d]: got %h want %h", k, isq_pc_out, 32'h100 + 32'(4 * k)); else pass_cnt++;
            total_cnt++; if (isq_ins_out !== 32'h2000 + 32'(k)) $display("FAIL b2b_ins[%0d]: got %h want %h", k, isq_ins_out, 32'h2000 + 32'(k)); else pass_cnt++;
            total_cnt++; if (isq_count !== 5'(exp_count)) $display("FAIL b2b_count[%0d]: got %0d want %0d", k, isq_count, exp_count); else pass_cnt++;
        end
        ifetch_valid = 1'b0;
        roll_back    = 1'b1;
        step();
        roll_back    = 1'b0;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL b2b_flush_count: got %0d want 0", isq_count); else pass_cnt++;
    endtask

    task automatic test_roll_back();
        rs_is_full   = 1'b1;
        ifetch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifetch_ins = 32'h3000 + 32'(i);
            ifetch_pc  = 32'h300 + 32'(4 * i);
            step();
        end
        ifetch_valid = 1'b0;
        rs_is_full   = 1'b0;
        step();
        total_cnt++; if (isq_count !== 5'd5) $display("FAIL rb_pre_count: got %0d want 5", isq_count); else pass_cnt++;
        total_cnt++; if (get_instruction !== 1'b1) $display("FAIL rb_pre_get: got %b want 1", get_instruction); else pass_cnt++;
        roll_back    = 1'b1;
        ifetch_valid = 1'b1;
        ifetch_ins   = 32'h0000_0bad;
        ifetch_pc    = 32'h999;
        step();
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL rb_count: got %0d want 0", isq_count); else pass_cnt++;
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL rb_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_pc_out !== 32'h300) $display("FAIL rb_pc_hold: got %h want 00000300", isq_pc_out); else pass_cnt++;
        roll_back    = 1'b0;
        ifetch_valid = 1'b0;
        step();
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL rb_after_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL rb_after_count: got %0d want 0", isq_count); else pass_cnt++;
    endtask

    task automatic test_pause();
        lsb_is_full  = 1'b1;
        ifetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifetch_ins = 32'h4000 + 32'(i);
            ifetch_pc  = 32'h200 + 32'(4 * i);
            step();
        end
        ifetch_valid = 1'b0;
        lsb_is_full  = 1'b0;
        step();
        total_cnt++; if (isq_pc_out !== 32'h200) $display("FAIL pause_pre_pc: got %h want 00000200", isq_pc_out); else pass_cnt++;
        rdy_in       = 1'b0;
        roll_back    = 1'b1;
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h777;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (get_instruction !== 1'b1) $display("FAIL pause_get[%0d]: got %b want 1", i, get_instruction); else pass_cnt++;
            total_cnt++; if (isq_pc_out !== 32'h200) $display("FAIL pause_pc[%0d]: got %h want 00000200", i, isq_pc_out); else pass_cnt++;
            total_cnt++; if (isq_ins_out !== 32'h4000) $display("FAIL pause_ins[%0d]: got %h want 00004000", i, isq_ins_out); else pass_cnt++;
            total_cnt++; if (isq_count !== 5'd3) $display("FAIL pause_count[%0d]: got %0d want 3", i, isq_count); else pass_cnt++;
        end
        rdy_in       = 1'b1;
        roll_back    = 1'b0;
        ifetch_valid = 1'b0;
        step();
        total_cnt++; if (get_instruction !== 1'b1) $display("FAIL resume_get: got %b want 1", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_pc_out !== 32'h204) $display("FAIL resume_pc: got %h want 00000204", isq_pc_out); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd2) $display("FAIL resume_count: got %0d want 2", isq_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ifetch_valid = 1'b1;
        ifetch_ins   = 32'h5000;
        ifetch_pc    = 32'h500;
        rst_n_in     = 1'b0;
        #1;
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL mid_reset_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL mid_reset_count: got %0d want 0", isq_count); else pass_cnt++;
        total_cnt++; if (isq_pc_out !== 32'h0) $display("FAIL mid_reset_pc: got %h want 0", isq_pc_out); else pass_cnt++;
        total_cnt++; if (isq_ins_out !== 32'h0) $display("FAIL mid_reset_ins: got %h want 0", isq_ins_out); else pass_cnt++;
        step();
        rst_n_in     = 1'b1;
        ifetch_valid = 1'b0;
        step();
        total_cnt++; if (get_instruction !== 1'b0) $display("FAIL mid_reset_after_get: got %b want 0", get_instruction); else pass_cnt++;
        total_cnt++; if (isq_count !== 5'd0) $display("FAIL mid_reset_after_count: got %0d want 0", isq_count); else pass_cnt++;
    endtask

    initial begin
        rdy_in       = 1'b1;
        roll_back    = 1'b0;
        ifetch_valid = 1'b0;
        ifetch_ins   = 32'h0;
        ifetch_pc    = 32'h0;
        rob_is_full  = 1'b0;
        rs_is_full   = 1'b0;
        lsb_is_full  = 1'b0;
        test_reset();
        test_single_push();
        test_stall_fill();
        test_back_to_back();
        test_roll_back();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_instruction_queue
